mcpu_kbd_fifo: RTL and testbench



---
 rtl/mcpu_kbd_fifo.sv | 111 +++++++++++
 tb/tb_mcpu_kbd_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_kbd_fifo.sv
// Keyboard input stage: synchronizes the raw keycode, turns key changes into events and
// queues them for the CPU's ALU Y port. Define MCPU_KBD_RELEASE_EN to also queue key releases.
module mcpu_kbd_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            keycode,
    input  logic                  pop,
    input  logic                  clear_overflow,
    output logic [DATA_WIDTH-1:0] key_out,
    output logic                  key_valid,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
`ifdef MCPU_KBD_RELEASE_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    logic [7:0]            s1, s2, prev;
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  ovf_q;
    logic                  push;
    logic [ENTRY_W-1:0]    entry;
    logic                  empty, full, do_pop, do_push, ovf_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 8'd0;
            s2   <= 8'd0;
            prev <= 8'd0;
        end else begin
            s1   <= keycode;
            s2   <= s1;
            prev <= s2;
        end
    end

    // s2 != prev with s2 == 0 implies prev holds the released code
    always_comb begin
        push = 1'b0;
`ifdef MCPU_KBD_RELEASE_EN
        entry = {1'b0, s2};
`else
        entry = s2;
`endif
        if (s2 != prev) begin
            if (s2 != 8'd0) begin
                push = 1'b1;
            end
`ifdef MCPU_KBD_RELEASE_EN
            else begin
                push  = 1'b1;
                entry = {1'b1, prev};
            end
`endif
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign ovf_set = push & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (ovf_set)             ovf_q <= 1'b1;
            else if (clear_overflow) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= entry;
    end

    always_comb begin
        key_out = '0;
        if (!empty) begin
            key_out[15]          = 1'b1;
            key_out[ENTRY_W-1:0] = mem[rd_ptr];
        end
    end

    assign key_valid  = ~empty;
    assign fifo_count = count;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mcpu_kbd_fifo.sv
// Bench for mcpu_kbd_fifo: vector table, hand-written full/overflow sequences and a random
// run against a queue-based model. Follows MCPU_KBD_RELEASE_EN if defined for the build.
module tb_mcpu_kbd_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  keycode = 8'd0;
    logic        pop = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [15:0] key_out;
    logic        key_valid;
    logic [3:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

`ifdef MCPU_KBD_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    mcpu_kbd_fifo #(.DATA_WIDTH(16), .DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .keycode(keycode), .pop(pop),
        .clear_overflow(clear_overflow), .key_out(key_out), .key_valid(key_valid),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: samp holds the keycodes sampled at the last three edges (oldest first);
    // an event seen at an edge compares the samples taken two and three edges earlier.
    int samp[$];
    int exp_q[$];
    bit m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  cur, old, word;
        bit  has_ev, popped, was_full;
        if (reset) begin
            samp = '{0, 0, 0};
            exp_q.delete();
            m_ovf = 1'b0;
            return;
        end
        old = samp[0];
        cur = samp[1];
        void'(samp.pop_front());
        samp.push_back(int'(keycode));
        has_ev = 1'b0;
        word   = 0;
        if (cur != old) begin
            if (cur != 0) begin
                has_ev = 1'b1;
                word   = 32'h8000 | cur;
            end else if (REL) begin
                has_ev = 1'b1;
                word   = 32'h8100 | old;
            end
        end
        was_full = (exp_q.size() == 8);
        popped   = pop && (exp_q.size() > 0);
        if (popped) void'(exp_q.pop_front());
        if (has_ev) begin
            if (!was_full || popped) exp_q.push_back(word);
            else m_ovf = 1'b1;
        end else if (clear_overflow) begin
            m_ovf = 1'b0;
        end
        if (has_ev && was_full && !popped) m_ovf = 1'b1;
        else if (clear_overflow && !(has_ev && was_full && !popped)) m_ovf = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_valid", key_valid, (exp_q.size() > 0));
        chk("model_key_out", key_out, (exp_q.size() > 0) ? exp_q[0] : 0);
        chk("model_count", fifo_count, exp_q.size());
        chk("model_overflow", overflow, m_ovf);
    endtask

    typedef struct {
        logic [7:0]  kc;
        logic        p, clr, rst;
        logic [15:0] out;
        logic        valid;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic [7:0] kc, logic p, logic clr, logic rst,
                                logic [15:0] out, logic valid, logic [3:0] cnt);
        vec_t v;
        v.kc = kc; v.p = p; v.clr = clr; v.rst = rst;
        v.out = out; v.valid = valid; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [15:0] drain [8];
        int hold;
        int r;

        tbl[0]  = mk(8'h00, 0, 0, 1, 16'h0000, 0, 0);
        tbl[1]  = mk(8'h41, 0, 0, 0, 16'h0000, 0, 0);
        tbl[2]  = mk(8'h41, 0, 0, 0, 16'h0000, 0, 0);
        tbl[3]  = mk(8'h41, 0, 0, 0, 16'h8041, 1, 1);
        tbl[4]  = mk(8'h42, 0, 0, 0, 16'h8041, 1, 1);
        tbl[5]  = mk(8'h42, 0, 0, 0, 16'h8041, 1, 1);
        tbl[6]  = mk(8'h42, 0, 0, 0, 16'h8041, 1, 2);
        tbl[7]  = mk(8'h00, 1, 0, 0, 16'h8042, 1, 1);
        tbl[8]  = mk(8'h00, 1, 0, 0, 16'h0000, 0, 0);
        // release of 0x42 lands while the FIFO is empty and a pop is requested
        tbl[9]  = REL ? mk(8'h00, 1, 0, 0, 16'h8142, 1, 1) : mk(8'h00, 1, 0, 0, 16'h0000, 0, 0);
        tbl[10] = mk(8'h00, 1, 0, 0, 16'h0000, 0, 0);
        tbl[11] = mk(8'h33, 0, 1, 0, 16'h0000, 0, 0);
        tbl[12] = mk(8'h33, 0, 0, 1, 16'h0000, 0, 0);
        tbl[13] = mk(8'h33, 0, 0, 0, 16'h0000, 0, 0);
        tbl[14] = mk(8'h33, 0, 0, 0, 16'h0000, 0, 0);
        tbl[15] = mk(8'h33, 0, 0, 0, 16'h8033, 1, 1);
        tbl[16] = mk(8'h33, 0, 0, 0, 16'h8033, 1, 1);
        tbl[17] = mk(8'h33, 0, 0, 0, 16'h8033, 1, 1);
        tbl[18] = mk(8'h33, 0, 0, 0, 16'h8033, 1, 1);

        samp = '{0, 0, 0};
        m_ovf = 1'b0;

        for (int i = 0; i < 19; i++) begin
            keycode = tbl[i].kc;
            pop = tbl[i].p;
            clear_overflow = tbl[i].clr;
            reset = tbl[i].rst;
            tick();
            chk($sformatf("tbl%0d_key_out", i), key_out, tbl[i].out);
            chk($sformatf("tbl%0d_valid", i), key_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_count", i), fifo_count, tbl[i].cnt);
            chk($sformatf("tbl%0d_overflow", i), overflow, 1'b0);
        end
        pop = 1'b0;
        clear_overflow = 1'b0;

        // Fill with nine presses; the ninth is dropped and sets overflow
        reset = 1'b1;
        keycode = 8'h51;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 9; c++) begin
            keycode = 8'h51 + 8'(c);
            for (int k = 0; k < 3; k++) tick();
        end
        chk("full_count", fifo_count, 4'd8);
        chk("full_overflow", overflow, 1'b1);
        chk("full_head", key_out, 16'h8051);

        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clear_overflow", overflow, 1'b0);
        chk("clear_count", fifo_count, 4'd8);

        // Push and pop land on the same edge while full
        keycode = 8'h5A;
        tick();
        tick();
        pop = 1'b1;
        tick();
        chk("fullpp_count", fifo_count, 4'd8);
        chk("fullpp_overflow", overflow, 1'b0);
        chk("fullpp_head", key_out, 16'h8052);

        drain = '{16'h8052, 16'h8053, 16'h8054, 16'h8055,
                  16'h8056, 16'h8057, 16'h8058, 16'h805A};
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("drain%0d", j), key_out, drain[j]);
            tick();
        end
        pop = 1'b0;
        chk("drain_count", fifo_count, 4'd0);
        chk("drain_valid", key_valid, 1'b0);
        chk("drain_key_out", key_out, 16'h0000);

        // Random run against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 6);
                case (r)
                    0, 1:    keycode = 8'h00;
                    2:       keycode = 8'h11;
                    3:       keycode = 8'h22;
                    4:       keycode = 8'h33;
                    default: keycode = 8'($urandom_range(1, 255));
                endcase
                hold = $urandom_range(1, 6);
            end
            hold--;
            pop = ($urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 10 : 45));
            clear_overflow = ($urandom_range(0, 99) < 5);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
